// File: rtl/aes_dec128_core_if.sv
// Command/response bundle between a host and the AES-128 decipher core.
// The host drives init/next/block and the core returns status and plaintext.
interface aes_dec128_core_if;
  logic         init;
  logic         next;
  logic [127:0] block;
  logic         ready;
  logic         key_valid;
  logic [127:0] result;
  logic         result_valid;

  modport master (output init, next, block, input ready, key_valid, result, result_valid);
  modport slave  (input init, next, block, output ready, key_valid, result, result_valid);
endinterface

// File: rtl/aes_dec128_core.sv
// Iterative AES-128 decipher with a hardwired key: 10-cycle key expansion on init,
// then one inverse round per cycle (10 cycles) per accepted block.
module aes_dec128_core #(
  parameter logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
  input  logic              clk,
  input  logic              reset,
  aes_dec128_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] aes_sbox(input logic [31:0] w);
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v = gf_inv(w[8*i +: 8]);
      aes_sbox[8*i +: 8] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] aes_inv_sbox(input logic [31:0] w);
    logic [7:0] s;
    for (int i = 0; i < 4; i++) begin
      s = w[8*i +: 8];
      aes_inv_sbox[8*i +: 8] = gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    end
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e       fsm_q, fsm_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] st_q, st_d;
  logic [127:0] result_q, result_d;
  logic [3:0]   rc_q, rc_d;
  logic         key_vld_q, key_vld_d;
  logic         res_vld_q, res_vld_d;

  logic         rk_we;
  logic [3:0]   rk_widx;
  logic [127:0] rk_wdat;

  // Key schedule: rk[rc] from rk[rc-1]
  logic [3:0]   rc_m1;
  logic [127:0] rk_prev, rk_next;
  logic [31:0]  t_w, w0, w1, w2, w3;

  assign rc_m1   = (rc_q == 4'd0) ? 4'd0 : rc_q - 4'd1;
  assign rk_prev = rk_q[rc_m1];
  assign t_w     = aes_sbox({rk_prev[23:0], rk_prev[31:24]}) ^ {rcon(rc_q), 24'h000000};
  assign w0      = rk_prev[127:96] ^ t_w;
  assign w1      = rk_prev[95:64]  ^ w0;
  assign w2      = rk_prev[63:32]  ^ w1;
  assign w3      = rk_prev[31:0]   ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  // Inverse round datapath; the last round (rc 0) skips InvMixColumns.
  logic [127:0] isr, ark, imc, round_out;

  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[127 - 8*(4*c + r) -: 8] = st_q[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
  end

  always_comb begin
    ark = '0;
    imc = '0;
    for (int c = 0; c < 4; c++)
      ark[127 - 32*c -: 32] = aes_inv_sbox(isr[127 - 32*c -: 32]);
    ark = ark ^ rk_q[rc_q];
    for (int c = 0; c < 4; c++)
      imc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
  end

  assign round_out = (rc_q == 4'd0) ? ark : imc;

  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    rc_d      = rc_q;
    result_d  = result_q;
    key_vld_d = key_vld_q;
    res_vld_d = res_vld_q;
    rk_we     = 1'b0;
    rk_widx   = rc_q;
    rk_wdat   = rk_next;
    case (fsm_q)
      IDLE: begin
        if (bus.init) begin
          fsm_d     = KEYEXP;
          rk_we     = 1'b1;
          rk_widx   = 4'd0;
          rk_wdat   = KEY;
          rc_d      = 4'd1;
          key_vld_d = 1'b0;
          res_vld_d = 1'b0;
        end else if (bus.next && key_vld_q) begin
          fsm_d     = DEC;
          st_d      = bus.block ^ rk_q[10];
          rc_d      = 4'd9;
          res_vld_d = 1'b0;
        end
      end
      KEYEXP: begin
        rk_we = 1'b1;
        rc_d  = rc_q + 4'd1;
        if (rc_q == 4'd10) begin
          fsm_d     = IDLE;
          rc_d      = 4'd0;
          key_vld_d = 1'b1;
        end
      end
      DEC: begin
        st_d = round_out;
        if (rc_q == 4'd0) begin
          fsm_d     = IDLE;
          result_d  = round_out;
          res_vld_d = 1'b1;
        end else begin
          rc_d = rc_q - 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= IDLE;
      st_q      <= '0;
      result_q  <= '0;
      rc_q      <= '0;
      key_vld_q <= 1'b0;
      res_vld_q <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      fsm_q     <= fsm_d;
      st_q      <= st_d;
      result_q  <= result_d;
      rc_q      <= rc_d;
      key_vld_q <= key_vld_d;
      res_vld_q <= res_vld_d;
      for (int i = 0; i < 11; i++)
        if (rk_we && rk_widx == i[3:0]) rk_q[i] <= rk_wdat;
    end
  end

  assign bus.ready        = (fsm_q == IDLE);
  assign bus.key_valid    = key_vld_q;
  assign bus.result       = result_q;
  assign bus.result_valid = res_vld_q;

endmodule

// File: tb/tb_aes_dec128_core.sv
// Directed-vector bench for aes_dec128_core: default-key and FIPS-197 key instances.
module tb_aes_dec128_core;

  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT3   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT3   = 128'h00112233445566778899aabbccddeeff;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  aes_dec128_core_if ifa ();
  aes_dec128_core_if ifb ();

  aes_dec128_core dut_a (.clk(clk), .reset(rst), .bus(ifa));
  aes_dec128_core #(.KEY(KEY_B)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Pulse init on dut_a; cyc = cycles after acceptance until ready is seen high.
  task automatic init_a(output int cyc);
    @(negedge clk) ifa.init = 1'b1;
    @(negedge clk) ifa.init = 1'b0;
    cyc = 1;
    while (ifa.ready !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Pulse next on dut_a and scramble block right after acceptance.
  task automatic decrypt_a(input logic [127:0] ct, output logic [127:0] res, output int lat);
    @(negedge clk) begin ifa.block = ct; ifa.next = 1'b1; end
    @(negedge clk) begin ifa.next = 1'b0; ifa.block = '1; end
    lat = 1;
    while (ifa.result_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = ifa.result;
  endtask

  task automatic test_reset;
    int bad;
    n_vec++; if (ifa.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ifa.ready); end
    n_vec++; if (ifa.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %b want 0", ifa.key_valid); end
    n_vec++; if (ifa.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_result_valid: got %b want 0", ifa.result_valid); end
    n_vec++; if (ifa.result !== 128'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", ifa.result); end
    @(negedge clk) begin ifa.block = CT1; ifa.next = 1'b1; end
    @(negedge clk) ifa.next = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.ready !== 1'b1 || ifa.result_valid !== 1'b0 || ifa.result !== 128'h0) bad++;
      @(negedge clk);
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL next_without_key: %0d disturbed cycles, want 0", bad); end
  endtask

  task automatic test_keyexp;
    int cyc;
    init_a(cyc);
    n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL keyexp_latency: ready back at +%0d want +11", cyc); end
    n_vec++; if (ifa.key_valid !== 1'b1) begin n_err++; $display("FAIL keyexp_key_valid: got %b want 1", ifa.key_valid); end
    n_vec++; if (dut_a.rk_q[10] !== RK10) begin n_err++; $display("FAIL keyexp_rk10: got %h want %h", dut_a.rk_q[10], RK10); end
  endtask

  task automatic test_decrypt;
    logic [127:0] res;
    int lat;
    decrypt_a(CT1, res, lat);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL dec1_latency: valid at +%0d want +11", lat); end
    n_vec++; if (res !== PT1) begin n_err++; $display("FAIL dec1_result: got %h want %h", res, PT1); end
    decrypt_a(CT2, res, lat);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL dec2_latency: valid at +%0d want +11", lat); end
    n_vec++; if (res !== PT2) begin n_err++; $display("FAIL dec2_result: got %h want %h", res, PT2); end
  endtask

  task automatic test_fips_key;
    int cyc;
    @(negedge clk) ifb.init = 1'b1;
    @(negedge clk) ifb.init = 1'b0;
    cyc = 1;
    while (ifb.ready !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    n_vec++; if (ifb.key_valid !== 1'b1) begin n_err++; $display("FAIL fips_key_valid: got %b want 1", ifb.key_valid); end
    @(negedge clk) begin ifb.block = CT3; ifb.next = 1'b1; end
    @(negedge clk) ifb.next = 1'b0;
    cyc = 1;
    while (ifb.result_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL fips_latency: valid at +%0d want +11", cyc); end
    n_vec++; if (ifb.result !== PT3) begin n_err++; $display("FAIL fips_result: got %h want %h", ifb.result, PT3); end
  endtask

  task automatic test_init_next_collision;
    logic [127:0] res;
    int cyc;
    @(negedge clk) begin ifa.block = CT1; ifa.init = 1'b1; ifa.next = 1'b1; end
    @(negedge clk) begin ifa.init = 1'b0; ifa.next = 1'b0; end
    cyc = 1;
    while (ifa.ready !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL collide_latency: ready back at +%0d want +11", cyc); end
    n_vec++; if (ifa.key_valid !== 1'b1) begin n_err++; $display("FAIL collide_key_valid: got %b want 1", ifa.key_valid); end
    n_vec++; if (ifa.result_valid !== 1'b0) begin n_err++; $display("FAIL collide_result_valid: got %b want 0", ifa.result_valid); end
    // A second next issued mid-round must be dropped, not queued.
    @(negedge clk) begin ifa.block = CT1; ifa.next = 1'b1; end
    @(negedge clk) ifa.next = 1'b0;
    repeat (3) @(negedge clk);
    ifa.block = CT2; ifa.next = 1'b1;
    @(negedge clk) ifa.next = 1'b0;
    cyc = 5;
    while (ifa.result_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    res = ifa.result;
    n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL busy_next_latency: valid at +%0d want +11", cyc); end
    n_vec++; if (res !== PT1) begin n_err++; $display("FAIL busy_next_result: got %h want %h", res, PT1); end
    repeat (15) @(negedge clk);
    n_vec++; if (ifa.ready !== 1'b1 || ifa.result_valid !== 1'b1) begin
      n_err++; $display("FAIL busy_next_queued: ready=%b valid=%b want 1 1", ifa.ready, ifa.result_valid);
    end
    n_vec++; if (ifa.result !== PT1) begin n_err++; $display("FAIL busy_next_hold: got %h want %h", ifa.result, PT1); end
  endtask

  task automatic test_reset_mid_dec;
    logic [127:0] res;
    int lat;
    int bad;
    @(negedge clk) begin ifa.block = CT2; ifa.next = 1'b1; end
    @(negedge clk) ifa.next = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (dut_a.rc_q !== 4'd5) begin n_err++; $display("FAIL mid_round_index: got %0d want 5", dut_a.rc_q); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (ifa.ready !== 1'b1 || ifa.key_valid !== 1'b0 || ifa.result_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_flags: ready=%b key_valid=%b valid=%b want 1 0 0",
                        ifa.ready, ifa.key_valid, ifa.result_valid);
    end
    n_vec++; if (ifa.result !== 128'h0) begin n_err++; $display("FAIL mid_reset_result: got %h want 0", ifa.result); end
    rst = 1'b0;
    @(negedge clk) begin ifa.block = CT1; ifa.next = 1'b1; end
    @(negedge clk) ifa.next = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (ifa.ready !== 1'b1 || ifa.result_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL post_reset_next: %0d disturbed cycles, want 0", bad); end
    init_a(lat);
    decrypt_a(CT1, res, lat);
    n_vec++; if (res !== PT1) begin n_err++; $display("FAIL post_reset_result: got %h want %h", res, PT1); end
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL post_reset_latency: valid at +%0d want +11", lat); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    ifa.init = 1'b0; ifa.next = 1'b0; ifa.block = '0;
    ifb.init = 1'b0; ifb.next = 1'b0; ifb.block = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_keyexp;
    test_decrypt;
    test_fips_key;
    test_init_next_collision;
    test_reset_mid_dec;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
